cart_image_loader: RTL
======================

CART_IMAGE_LOADER -- requirements
Module: cart_image_loader

Interface
REQ-001 Parameter DATA_W, default 32: flash/memory word width in bits, multiple of 8.
REQ-002 Parameter LOAD_WORDS, default 32768: image data words per slot; power of two, 2 or more.
REQ-003 Parameter SLOTS, default 16: number of cartridge slots in flash, 1 or more.
REQ-004 Parameter SLOT_SHIFT, default 18: log2 of the byte stride between slots.
REQ-005 Parameter FLASH_BASE, default 24'h100000: byte address of slot 0.
REQ-006 Parameter SETTLE_CYCLES, default 255: idle cycles between image load and cart_ready.
REQ-007 Parameter CHECK_EN, default 1: 1 fetches and verifies a checksum word.
REQ-008 Parameter TIMEOUT, default 4095: maximum cycles to wait for flash_ready per word.
REQ-009 Port clock, input, 1: sole clock, rising edge.
REQ-010 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-011 Port reload, input, 1: level; abort and restart the load from slot index.
REQ-012 Port index, input, IW=max(1,clog2(SLOTS)): slot to load on reload.
REQ-013 Port flash_valid, output, 1: word request to the flash controller.
REQ-014 Port flash_ready, input, 1: one-cycle pulse; flash_rdata is valid this cycle.
REQ-015 Port flash_addr, output, 24: byte address of the requested word.
REQ-016 Port flash_rdata, input, DATA_W: returned word.
REQ-017 Port mem_wren, output, 1: write strobe to image RAM.
REQ-018 Port mem_addr, output, clog2(LOAD_WORDS): image RAM word address.
REQ-019 Port mem_wdata, output, DATA_W: image RAM write data.
REQ-020 Port flags_out, output, DATA_W: mapper flags word.
REQ-021 Port cart_ready, output, 1: image loaded, verified and settled.
REQ-022 Port busy, output, 1: a load is in progress.
REQ-023 Port err_code, output, 2: 0 none, 1 timeout, 2 checksum, 3 bad slot.

Function
REQ-024 The states SHALL be LOAD, FLAGS, CHECK, SETTLE, READY and ERROR; after reset the block SHALL enter LOAD with slot 0.
REQ-025 flash_valid SHALL be high in LOAD, FLAGS and CHECK, and low in all other states.
REQ-026 flash_addr SHALL equal FLASH_BASE + (slot << SLOT_SHIFT) + word_idx*(DATA_W/8), computed modulo 2^24.
REQ-027 word_idx SHALL run 0..LOAD_WORDS-1 in LOAD, equal LOAD_WORDS in FLAGS, and equal LOAD_WORDS+1 in CHECK; it SHALL advance only on flash_ready.
REQ-028 In LOAD, each flash_ready SHALL produce a one-cycle mem_wren on the next clock, with mem_addr=word_idx and mem_wdata=flash_rdata both registered.
REQ-029 The ready that accepts the last LOAD word SHALL move the state to FLAGS.
REQ-030 In FLAGS, flash_ready SHALL latch flags_out=flash_rdata without asserting mem_wren, then move to CHECK if CHECK_EN=1, else to SETTLE.
REQ-031 The checksum SHALL be the sum modulo 2^DATA_W of all LOAD words plus the flags word, cleared at the start of each load.
REQ-032 In CHECK, flash_ready SHALL compare flash_rdata with the checksum: on a match, go to SETTLE; on a mismatch, go to ERROR with err_code=2.
REQ-033 SETTLE SHALL last exactly SETTLE_CYCLES+1 cycles and then enter READY; cart_ready SHALL be 1 only in READY.
REQ-034 A per-word wait counter SHALL clear on each flash_ready and on each state entry; reaching TIMEOUT with no ready SHALL give ERROR with err_code=1.
REQ-035 A reload with index >= SLOTS SHALL give ERROR with err_code=3 and no flash request.
REQ-036 A reload high in any state SHALL, on that clock, clear cart_ready, flags_out, the checksum, word_idx and err_code, latch the slot, and enter LOAD; a held reload SHALL keep the block restarting.
REQ-037 A flash_ready in the same cycle as reload SHALL be discarded, with no mem_wren.
REQ-038 ERROR and READY SHALL hold until reload or reset.
REQ-039 busy SHALL be 1 in LOAD, FLAGS, CHECK and SETTLE.

Reset
REQ-040 While reset_n=0, the block SHALL hold flash_valid=0, mem_wren=0, mem_addr=0, mem_wdata=0, flags_out=0, cart_ready=0, busy=0, err_code=0, slot=0 and state LOAD, and SHALL clear all counters.
REQ-041 Release of reset_n SHALL start a slot-0 load, with flash_valid=1 on the first clock after release.
REQ-042 Reset SHALL dominate reload.

Verification (LOAD_WORDS=4, SETTLE_CYCLES=3, TIMEOUT=15, SLOTS=3)
REQ-043 Reset release, flash model returns words 1,2,3,4, flags 8'h15 and sum 8'h1F -> exactly four mem_wren at addresses 0..3 with data 1..4; flags_out=8'h15; cart_ready rises 4 cycles after the CHECK ready; err_code=0.
REQ-044 Same stimulus but sum word 8'h20 -> ERROR, err_code=2, cart_ready stays 0, busy=0.
REQ-045 Flash withholds ready on word 2 -> err_code=1 at cycle 15 of waiting; flash_valid drops.
REQ-046 reload with index=2 during LOAD word 1, with a coincident flash_ready -> no mem_wren from that ready; next flash_addr=FLASH_BASE+(2<<SLOT_SHIFT); mem_addr restarts at 0.
REQ-047 reload with index=3 -> ERROR, err_code=3, flash_valid never asserted.
REQ-048 reset_n pulsed low mid-SETTLE -> all outputs at reset values immediately, with no clock needed; a slot-0 load restarts after release.

Source files
------------

// File: rtl/cart_image_loader.sv
// Cartridge image loader: copies one flash slot into image RAM, latches the mapper flags word,
// optionally verifies a trailing checksum, then waits a settle period before asserting cart_ready.
module cart_image_loader #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned LOAD_WORDS    = 32768,
  parameter int unsigned SLOTS         = 16,
  parameter int unsigned SLOT_SHIFT    = 18,
  parameter logic [23:0] FLASH_BASE    = 24'h100000,
  parameter int unsigned SETTLE_CYCLES = 255,
  parameter int unsigned CHECK_EN      = 1,
  parameter int unsigned TIMEOUT       = 4095,
  localparam int unsigned IW           = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int unsigned AW           = $clog2(LOAD_WORDS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              reload,
  input  logic [IW-1:0]     index,
  output logic              flash_valid,
  input  logic              flash_ready,
  output logic [23:0]       flash_addr,
  input  logic [DATA_W-1:0] flash_rdata,
  output logic              mem_wren,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] flags_out,
  output logic              cart_ready,
  output logic              busy,
  output logic [1:0]        err_code
);

  localparam int unsigned WIW   = AW + 1;
  localparam int unsigned WW    = $clog2(TIMEOUT + 2);
  localparam int unsigned SW    = $clog2(SETTLE_CYCLES + 2);
  localparam int unsigned Bytes = DATA_W / 8;

  localparam logic [WIW-1:0] LastIdx  = WIW'(LOAD_WORDS - 1);
  localparam logic [WIW-1:0] FlagsIdx = WIW'(LOAD_WORDS);
  localparam logic [WIW-1:0] CheckIdx = WIW'(LOAD_WORDS + 1);
  localparam logic [WW-1:0]  WaitMax  = WW'(TIMEOUT - 1);
  localparam logic [SW-1:0]  SettleMax = SW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    StLoad,
    StFlags,
    StCheck,
    StSettle,
    StReady,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     slot_q, slot_d;
  logic [WIW-1:0]    word_idx_q, word_idx_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              mem_wren_q, mem_wren_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] flags_q, flags_d;
  logic [1:0]        err_q, err_d;
  logic              flash_valid_q, flash_valid_d;
  logic              busy_q, busy_d;
  logic              cart_ready_q, cart_ready_d;
  logic              req_state;
  logic              accept;

  assign req_state = (state_q == StLoad) || (state_q == StFlags) || (state_q == StCheck);
  // A ready only counts while a request is actually outstanding.
  assign accept    = flash_valid_q && flash_ready;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    wait_d      = wait_q;
    settle_d    = settle_q;
    mem_wren_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    flags_d     = flags_q;
    err_d       = err_q;

    if (reload) begin
      slot_d     = index;
      word_idx_d = '0;
      csum_d     = '0;
      wait_d     = '0;
      settle_d   = '0;
      flags_d    = '0;
      err_d      = 2'd0;
      state_d    = StLoad;
      if (32'(index) >= SLOTS) begin
        state_d = StError;
        err_d   = 2'd3;
      end
    end else begin
      if (req_state && flash_valid_q) begin
        if (flash_ready) begin
          wait_d = '0;
        end else if (wait_q == WaitMax) begin
          state_d = StError;
          err_d   = 2'd1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      case (state_q)
        StLoad: begin
          if (accept) begin
            mem_wren_d  = 1'b1;
            mem_addr_d  = word_idx_q[AW-1:0];
            mem_wdata_d = flash_rdata;
            csum_d      = csum_q + flash_rdata;
            word_idx_d  = word_idx_q + WIW'(1);
            if (word_idx_q == LastIdx) begin
              state_d = StFlags;
            end
          end
        end
        StFlags: begin
          if (accept) begin
            flags_d    = flash_rdata;
            csum_d     = csum_q + flash_rdata;
            word_idx_d = CheckIdx;
            state_d    = (CHECK_EN != 0) ? StCheck : StSettle;
          end
        end
        StCheck: begin
          if (accept) begin
            if (flash_rdata == csum_q) begin
              state_d = StSettle;
            end else begin
              state_d = StError;
              err_d   = 2'd2;
            end
          end
        end
        StSettle: begin
          if (settle_q == SettleMax) begin
            state_d = StReady;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
        default: ;
      endcase

      if (state_d != state_q) begin
        wait_d   = '0;
        settle_d = '0;
      end
    end

    flash_valid_d = (state_d == StLoad) || (state_d == StFlags) || (state_d == StCheck);
    busy_d        = flash_valid_d || (state_d == StSettle);
    cart_ready_d  = (state_d == StReady);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StLoad;
      slot_q        <= '0;
      word_idx_q    <= '0;
      csum_q        <= '0;
      wait_q        <= '0;
      settle_q      <= '0;
      mem_wren_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      flags_q       <= '0;
      err_q         <= 2'd0;
      flash_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      cart_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      word_idx_q    <= word_idx_d;
      csum_q        <= csum_d;
      wait_q        <= wait_d;
      settle_q      <= settle_d;
      mem_wren_q    <= mem_wren_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      flags_q       <= flags_d;
      err_q         <= err_d;
      flash_valid_q <= flash_valid_d;
      busy_q        <= busy_d;
      cart_ready_q  <= cart_ready_d;
    end
  end

  assign flash_addr  = FLASH_BASE + (24'(slot_q) << SLOT_SHIFT) + 24'(word_idx_q) * 24'(Bytes);
  assign flash_valid = flash_valid_q;
  assign mem_wren    = mem_wren_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign flags_out   = flags_q;
  assign cart_ready  = cart_ready_q;
  assign busy        = busy_q;
  assign err_code    = err_q;

endmodule
